// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the instruction-fetch front end
package fetch_unit_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for the fetch queue and the in-flight PC queue
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  // Callers guarantee a free slot on push, so only underflow is guarded here.
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: credit-limited imem requests, prefetch queue, redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_ins,
  output logic [XLEN-1:0] dec_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0]    fetch_pc;
  logic [CW-1:0]      q_count;
  logic [CW-1:0]      pc_count;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      outstanding;
  logic               req_fire;
  logic               resp_keep;
  logic               pop_fire;
  logic [XLEN-1:0]    resp_pc;
  logic [XLEN+31:0]   q_head;

  // Live requests either still own a PC slot or are already marked stale.
  assign outstanding = pc_count + drop_cnt;

  assign imem_req_valid = !rst && !redirect_valid &&
                          ((int'(q_count) + int'(outstanding)) < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && !redirect_valid && (drop_cnt == '0);

  assign dec_valid         = !rst && (q_count != '0);
  assign pop_fire          = dec_valid && dec_ready && !redirect_valid;
  assign {dec_pc, dec_ins} = q_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC & ~XLEN'(3);
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      drop_cnt <= outstanding - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .flush     (redirect_valid),
    .count     (pc_count),
    .head      (resp_pc)
  );

  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data ({resp_pc, imem_resp_data}),
    .pop       (pop_fire),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_ins         (dec_ins),
    .dec_pc          (dec_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // imem model: fixed latency, in order, reset by the same rst
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;

  always @(posedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_resp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = img(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1;
    tick(); tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    rst = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr: got %h expected 00000000", imem_req_addr); end
  endtask

  logic [31:0] exp_pc;

  task automatic test_sequential();
    int n = 0;
    int gaps = 0;
    bit seen = 0;
    dec_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 60 && n < 12; i++) begin
      tick();
      if (dec_valid) begin
        seen = 1;
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL seq_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end else if (seen) gaps++;
    end
    checks++; if (n != 12) begin errors++; $display("FAIL seq_count: got %0d expected 12", n); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL seq_gaps: got %0d expected 0", gaps); end
  endtask

  task automatic test_stall();
    int n = 0;
    tick();
    dec_ready = 1'b0;
    repeat (10) tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (dut.q_count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", dut.q_count); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin errors++; $display("FAIL stall_head: valid %b pc %h, expected 1 %h", dec_valid, dec_pc, exp_pc); end
    exp_pc += 32'd4;
    dec_ready = 1'b1;
    for (int i = 0; i < 40 && n < 7; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL stall_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 7) begin errors++; $display("FAIL stall_release_count: got %0d expected 7", n); end
  endtask

  task automatic test_redirect_drop();
    int n = 0;
    rst = 1'b1; imem_req_ready = 1'b0; dec_ready = 1'b1;
    tick();
    lat = 3;
    tick();
    rst = 1'b0; imem_req_ready = 1'b1;
    tick(); tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    checks++; if (dut.drop_cnt !== 3'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", dut.drop_cnt); end
    exp_pc = 32'h100;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL drop_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL drop_count: got %0d expected 3", n); end
  endtask

  task automatic test_redirect_collide();
    int n = 0;
    bit found = 0;
    rst = 1'b1;
    tick();
    lat = 1; rst = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dec_valid && imem_resp_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL collide_setup: got 0 expected 1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: got %b expected 0", dec_valid); end
    checks++; if (dut.drop_cnt !== 3'd0) begin errors++; $display("FAIL collide_drop_cnt: got %0d expected 0", dut.drop_cnt); end
    exp_pc = 32'h200;
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL collide_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL collide_count: got %0d expected 3", n); end
  endtask

  task automatic test_align_wrap();
    int n = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h100;
    for (int i = 0; i < 30 && n < 2; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc) begin errors++; $display("FAIL align_item %0d: pc %h expected %h", n, dec_pc, exp_pc); end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL align_count: got %0d expected 2", n); end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    n = 0; exp_pc = 32'h400;
    for (int i = 0; i < 30 && n < 2; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc) begin errors++; $display("FAIL b2b_item %0d: pc %h expected %h", n, dec_pc, exp_pc); end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: valid %b addr %h, expected 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    n = 0; exp_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL wrap_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", n); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rst = 1'b1;
    tick();
    lat = 3; rst = 1'b0; dec_ready = 1'b0; imem_req_ready = 1'b1;
    repeat (5) tick();
    checks++; if (dut.q_count !== 3'd2 || dut.outstanding !== 3'd2) begin
      errors++; $display("FAIL mid_setup: count %0d outstanding %0d, expected 2 2", dut.q_count, dut.outstanding);
    end
    rst = 1'b1;
    tick();
    checks++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: dec_valid %b req_valid %b, expected 0 0", dec_valid, imem_req_valid);
    end
    checks++; if (dut.q_count !== 3'd0 || dut.outstanding !== 3'd0) begin
      errors++; $display("FAIL mid_reset_state: count %0d outstanding %0d, expected 0 0", dut.q_count, dut.outstanding);
    end
    rst = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL mid_first_req: valid %b addr %h, expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    dec_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (dec_valid) begin
        checks++;
        if (dec_pc !== exp_pc || dec_ins !== img(exp_pc)) begin
          errors++; $display("FAIL mid_item %0d: pc %h ins %h, expected pc %h ins %h", n, dec_pc, dec_ins, exp_pc, img(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL mid_count: got %0d expected 3", n); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_collide();
    test_align_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
